reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
// Buffers renamed instructions from dispatch until both source operands are valid, then drives one
// instruction per cycle onto issue_bus_if (cmp side) toward the combo units and the ROB. Snoops
// the result (CDB) bus for operand wake-up. One instance per functional-unit class.
// PARAMETERS
// XLEN  32  data/address width
// SIZE  8   number of entries (power of two not required, >= 2)
// PORTS
// clock       in   1              clock
// reset       in   1              asynchronous, active-high
// flush       in   1              pipeline flush, clears all entries and the issue register
// in_valid    in   1              dispatch offers an instruction
// in_ready    out  1              entry free; transfer on in_valid & in_ready
// in_*        in   per field      address, immediate, data_1, data_2, valid_1, valid_2, instr_name,
//                                 instr_type, regs (registers_t), flags (flag_vector_t)
// cdb_valid   in   1              result broadcast valid
// cdb_tag     in   6              renamed destination register of the result
// cdb_data    in   XLEN           result value
// issue       cmp  modport        issue_bus_if.cmp: all bus fields, driven from the issue register
// out_valid   out  1              issue register holds an instruction
// out_ready   in   1              consumer takes it; transfer on out_valid & out_ready
// count       out  $clog2(SIZE+1) occupied entries (excluding issue register)
// BEHAVIOUR
// - Reset/flush: all entries invalid, count=0, out_valid=0, issue bus fields = clear() values
//   (zeros, instr_name=UNKNOWN, instr_type=XX, regs all 6'h00, flags all 0). flush beats all.
// - Storage: age-ordered compacting array, entry 0 oldest. Insert writes at index count.
// - in_ready = !flush && count < SIZE; no pass-through, so full blocks insert even if issuing.
// - Wake-up: each edge, for every valid entry with valid_k=0 and regs.src_k==cdb_tag and
//   cdb_valid, set data_k=cdb_data, valid_k=1 (k=1,2; both may hit). Same rule applies to the
//   instruction being inserted that cycle (no lost wake-up). Tag 6'h00 never matches.
// - Ready entry: valid & valid_1 & valid_2 as stored at start of cycle (wake-up visible next cycle).
// - Issue register loads when (!out_valid || out_ready) and a ready entry exists: selects lowest
//   index ready entry, removes it, entries above shift down by one. Same edge may also insert;
//   new entry lands at count-1 (after shift) so order is preserved. count updates +1/-1/0.
// - If out_valid & !out_ready: issue register and bus fields hold stable; no selection.
// - If out_ready with no ready entry: out_valid->0, bus fields return to clear() values.
// - Latency: insert with both operands valid at edge E0 -> out_valid=1 after edge E1.
// - Issue register never snoops CDB (operands already valid).
// TESTING
// 1 reset mid-stream with 3 entries and out_valid=1 -> count=0, out_valid=0, bus = clear() values.
// 2 insert A(valid_1=valid_2=1) at E0, out_ready=1 -> out_valid after E1, issue.address=A.address.
// 3 insert B(valid_1=0, src_1=6'h05); cdb_valid, cdb_tag=5, cdb_data=32'hDEAD_BEEF two edges later
//   -> B issues with data_1=32'hDEAD_BEEF, valid_1=1; cdb on same cycle as insert also captured.
// 4 fill SIZE=8 with non-ready entries -> in_ready=0, count=8; wake entry 3 -> it issues, count=7,
//   in_ready=1; remaining entries keep original relative order.
// 5 two ready entries (idx 1, 4), out_ready=0 for 3 cycles -> bus fields stable; then entry 1
//   issues first, entry 4 (now idx 3) next cycle.
// 6 flush with in_valid=1 -> insert dropped, count=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/reservation_station_if.sv
// Shared instruction-field types and the issue bus that carries one selected instruction
// from a reservation station toward the combo units and the ROB.
package rs_pkg;

  typedef enum logic [2:0] {
    UNKNOWN = 3'd0,
    ADD     = 3'd1,
    SUB     = 3'd2,
    LOAD    = 3'd3,
    STORE   = 3'd4,
    BRANCH  = 3'd5
  } instr_name_t;

  typedef enum logic [1:0] {
    XX     = 2'd0,
    R_TYPE = 2'd1,
    I_TYPE = 2'd2,
    B_TYPE = 2'd3
  } instr_type_t;

  typedef struct packed {
    logic [5:0] dst;
    logic [5:0] src_1;
    logic [5:0] src_2;
  } registers_t;

  typedef struct packed {
    logic speculative;
    logic predicted_taken;
    logic exception;
  } flag_vector_t;

endpackage

interface issue_bus_if #(parameter int XLEN = 32);
  import rs_pkg::*;

  logic [XLEN-1:0] address;
  logic [XLEN-1:0] immediate;
  logic [XLEN-1:0] data_1;
  logic [XLEN-1:0] data_2;
  logic            valid_1;
  logic            valid_2;
  instr_name_t     instr_name;
  instr_type_t     instr_type;
  registers_t      regs;
  flag_vector_t    flags;

  modport cmp (
    output address, immediate, data_1, data_2, valid_1, valid_2,
    output instr_name, instr_type, regs, flags
  );

  modport combo (
    input address, immediate, data_1, data_2, valid_1, valid_2,
    input instr_name, instr_type, regs, flags
  );

endinterface

// File: rtl/reservation_station.sv
// Age-ordered reservation station: holds dispatched instructions, wakes operands from the CDB,
// and moves the oldest ready entry into a single issue register each cycle.
module reservation_station
  import rs_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SIZE = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_address,
  input  logic [XLEN-1:0]           in_immediate,
  input  logic [XLEN-1:0]           in_data_1,
  input  logic [XLEN-1:0]           in_data_2,
  input  logic                      in_valid_1,
  input  logic                      in_valid_2,
  input  instr_name_t               in_instr_name,
  input  instr_type_t               in_instr_type,
  input  registers_t                in_regs,
  input  flag_vector_t              in_flags,
  input  logic                      cdb_valid,
  input  logic [5:0]                cdb_tag,
  input  logic [XLEN-1:0]           cdb_data,
  issue_bus_if.cmp                  issue,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(SIZE+1)-1:0] count
);

  localparam int CW = $clog2(SIZE + 1);
  localparam int IW = $clog2(SIZE);

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] immediate;
    logic [XLEN-1:0] data_1;
    logic [XLEN-1:0] data_2;
    logic            valid_1;
    logic            valid_2;
    instr_name_t     instr_name;
    instr_type_t     instr_type;
    registers_t      regs;
    flag_vector_t    flags;
  } entry_t;

  // All-zero encodes UNKNOWN / XX / zero registers and flags, i.e. the idle bus value.
  localparam entry_t ENTRY_CLEAR = '0;

  entry_t        entry_q [SIZE];
  entry_t        entry_d [SIZE];
  entry_t        woken   [SIZE];
  entry_t        shifted [SIZE];
  entry_t        issue_q, issue_d;
  entry_t        in_entry;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] ins_idx;
  logic [IW-1:0] sel;
  logic          have_ready, can_load, do_issue, do_insert;

  // Tag 0 is the "no producer" register, so it must never wake an operand.
  function automatic entry_t wake(input entry_t e, input logic v, input logic [5:0] tag,
                                  input logic [XLEN-1:0] data);
    wake = e;
    if (v && tag != 6'h00) begin
      if (!e.valid_1 && e.regs.src_1 == tag) begin
        wake.data_1  = data;
        wake.valid_1 = 1'b1;
      end
      if (!e.valid_2 && e.regs.src_2 == tag) begin
        wake.data_2  = data;
        wake.valid_2 = 1'b1;
      end
    end
  endfunction

  always_comb begin
    in_entry.address    = in_address;
    in_entry.immediate  = in_immediate;
    in_entry.data_1     = in_data_1;
    in_entry.data_2     = in_data_2;
    in_entry.valid_1    = in_valid_1;
    in_entry.valid_2    = in_valid_2;
    in_entry.instr_name = in_instr_name;
    in_entry.instr_type = in_instr_type;
    in_entry.regs       = in_regs;
    in_entry.flags      = in_flags;

    in_ready  = !flush && (count_q < CW'(SIZE));
    do_insert = in_valid && in_ready;
    can_load  = !out_valid_q || out_ready;

    // Readiness uses start-of-cycle operand state; a wake-up this edge is seen next cycle.
    have_ready = 1'b0;
    sel        = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (CW'(i) < count_q && entry_q[i].valid_1 && entry_q[i].valid_2) begin
        have_ready = 1'b1;
        sel        = IW'(i);
      end
    end
    do_issue = can_load && have_ready;
    ins_idx  = count_q - CW'(do_issue);

    for (int i = 0; i < SIZE; i++) woken[i] = wake(entry_q[i], cdb_valid, cdb_tag, cdb_data);
    for (int i = 0; i < SIZE - 1; i++) shifted[i] = woken[i + 1];
    shifted[SIZE-1] = ENTRY_CLEAR;

    for (int i = 0; i < SIZE; i++) begin
      entry_d[i] = (do_issue && IW'(i) >= sel) ? shifted[i] : woken[i];
      if (do_insert && CW'(i) == ins_idx) entry_d[i] = wake(in_entry, cdb_valid, cdb_tag, cdb_data);
    end
    count_d = count_q + CW'(do_insert) - CW'(do_issue);

    issue_d     = issue_q;
    out_valid_d = out_valid_q;
    if (do_issue) begin
      issue_d     = entry_q[sel];
      out_valid_d = 1'b1;
    end else if (can_load) begin
      issue_d     = ENTRY_CLEAR;
      out_valid_d = 1'b0;
    end

    if (flush) begin
      for (int i = 0; i < SIZE; i++) entry_d[i] = ENTRY_CLEAR;
      count_d     = '0;
      issue_d     = ENTRY_CLEAR;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) entry_q[i] <= ENTRY_CLEAR;
      count_q     <= '0;
      issue_q     <= ENTRY_CLEAR;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < SIZE; i++) entry_q[i] <= entry_d[i];
      count_q     <= count_d;
      issue_q     <= issue_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign count            = count_q;
  assign issue.address    = issue_q.address;
  assign issue.immediate  = issue_q.immediate;
  assign issue.data_1     = issue_q.data_1;
  assign issue.data_2     = issue_q.data_2;
  assign issue.valid_1    = issue_q.valid_1;
  assign issue.valid_2    = issue_q.valid_2;
  assign issue.instr_name = issue_q.instr_name;
  assign issue.instr_type = issue_q.instr_type;
  assign issue.regs       = issue_q.regs;
  assign issue.flags      = issue_q.flags;

endmodule

// File: tb/tb_reservation_station.sv
// Scenario-driven bench for reservation_station: issued instructions are checked against a
// queue of expected results pushed as stimulus is applied.
module tb_reservation_station;
  import rs_pkg::*;

  typedef struct {
    logic [31:0] address;
    logic [31:0] data_1;
    logic [31:0] data_2;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset, flush, in_valid, in_ready;
  logic [31:0]  in_address, in_immediate, in_data_1, in_data_2;
  logic         in_valid_1, in_valid_2;
  instr_name_t  in_instr_name;
  instr_type_t  in_instr_type;
  registers_t   in_regs;
  flag_vector_t in_flags;
  logic         cdb_valid;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic         out_valid, out_ready;
  logic [3:0]   count;

  exp_t exp_q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  issue_bus_if #(.XLEN(32)) bus ();

  reservation_station #(.XLEN(32), .SIZE(8)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_address(in_address), .in_immediate(in_immediate),
    .in_data_1(in_data_1), .in_data_2(in_data_2),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .in_instr_name(in_instr_name), .in_instr_type(in_instr_type),
    .in_regs(in_regs), .in_flags(in_flags),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue(bus), .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  always #5 clock = ~clock;

  // Inputs change 2 time units after a rising edge, so at the falling edge an
  // out_valid & out_ready pair is exactly what the next rising edge will transfer.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL sb_unexpected issue address=%h with no expected entry", bus.address);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.address !== mon_e.address || bus.data_1 !== mon_e.data_1 ||
            bus.data_2 !== mon_e.data_2 || bus.valid_1 !== 1'b1 || bus.valid_2 !== 1'b1)
          $display("[TB] FAIL sb_issue got addr=%h d1=%h d2=%h v=%b%b want addr=%h d1=%h d2=%h v=11",
                   bus.address, bus.data_1, bus.data_2, bus.valid_1, bus.valid_2,
                   mon_e.address, mon_e.data_1, mon_e.data_2);
        else passed++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set_insert(input logic [31:0] addr, input logic v1, input logic [5:0] s1,
                            input logic [31:0] d1, input logic v2, input logic [5:0] s2,
                            input logic [31:0] d2);
    in_valid      = 1'b1;
    in_address    = addr;
    in_immediate  = addr ^ 32'h0000_FFFF;
    in_data_1     = d1;
    in_valid_1    = v1;
    in_data_2     = d2;
    in_valid_2    = v2;
    in_instr_name = ADD;
    in_instr_type = R_TYPE;
    in_regs.dst   = 6'd40;
    in_regs.src_1 = s1;
    in_regs.src_2 = s2;
    in_flags      = '0;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e.address = a;
    e.data_1  = d1;
    e.data_2  = d2;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    total++; if (count !== 4'd0) $display("[TB] FAIL reset_count got %0d want 0", count); else passed++;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (bus.address !== 32'h0 || bus.instr_name !== UNKNOWN || bus.regs !== 18'h0)
      $display("[TB] FAIL reset_bus got addr=%h name=%0d regs=%h want 0/UNKNOWN/0", bus.address, bus.instr_name, bus.regs);
    else passed++;
    reset = 1'b0;
    step();
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    set_insert(32'h100, 1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22);
    push_exp(32'h100, 32'h11, 32'h22);
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || count !== 4'd1)
      $display("[TB] FAIL basic_e0 got out_valid=%b count=%0d want 0/1", out_valid, count);
    else passed++;
    step();
    total++; if (out_valid !== 1'b1 || bus.address !== 32'h100 || count !== 4'd0)
      $display("[TB] FAIL basic_e1 got out_valid=%b addr=%h count=%0d want 1/100/0", out_valid, bus.address, count);
    else passed++;
    step();
    total++; if (out_valid !== 1'b0 || bus.address !== 32'h0 || bus.instr_name !== UNKNOWN)
      $display("[TB] FAIL basic_drain got out_valid=%b addr=%h want 0/0", out_valid, bus.address);
    else passed++;
  endtask

  task automatic test_wakeup();
    set_insert(32'h200, 1'b0, 6'd5, 32'h0, 1'b1, 6'd6, 32'h7);
    push_exp(32'h200, 32'hDEAD_BEEF, 32'h7);
    step();
    in_valid = 1'b0;
    step();
    total++; if (count !== 4'd1 || out_valid !== 1'b0)
      $display("[TB] FAIL wake_wait got count=%0d out_valid=%b want 1/0", count, out_valid);
    else passed++;
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'hDEAD_BEEF;
    step();
    cdb_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL wake_latency got out_valid=%b want 0", out_valid); else passed++;
    step();
    total++; if (out_valid !== 1'b1 || bus.data_1 !== 32'hDEAD_BEEF || bus.valid_1 !== 1'b1 || count !== 4'd0)
      $display("[TB] FAIL wake_issue got v=%b d1=%h v1=%b count=%0d want 1/deadbeef/1/0", out_valid, bus.data_1, bus.valid_1, count);
    else passed++;
    step();
    set_insert(32'h300, 1'b0, 6'd9, 32'h0, 1'b0, 6'd9, 32'h0);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h55;
    push_exp(32'h300, 32'h55, 32'h55);
    step();
    in_valid = 1'b0; cdb_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || bus.data_2 !== 32'h55)
      $display("[TB] FAIL wake_same_cycle got out_valid=%b d2=%h want 1/55", out_valid, bus.data_2);
    else passed++;
    step();
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_insert(32'h400 + 32'(4 * i), 1'b0, 6'(10 + i), 32'h0, 1'b1, 6'd0, 32'h1000 + 32'(i));
      step();
    end
    in_valid = 1'b0;
    total++; if (count !== 4'd8 || in_ready !== 1'b0)
      $display("[TB] FAIL fill_full got count=%0d in_ready=%b want 8/0", count, in_ready);
    else passed++;
    set_insert(32'h4FC, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
    step();
    in_valid = 1'b0;
    total++; if (count !== 4'd8 || out_valid !== 1'b0)
      $display("[TB] FAIL fill_blocked got count=%0d out_valid=%b want 8/0", count, out_valid);
    else passed++;
    out_ready = 1'b1;
    cdb_valid = 1'b1; cdb_tag = 6'd13; cdb_data = 32'hA00D;
    push_exp(32'h40C, 32'hA00D, 32'h1003);
    step();
    cdb_valid = 1'b0;
    step();
    total++; if (count !== 4'd7 || in_ready !== 1'b1 || out_valid !== 1'b1 || bus.address !== 32'h40C)
      $display("[TB] FAIL fill_wake3 got count=%0d in_ready=%b v=%b addr=%h want 7/1/1/40c", count, in_ready, out_valid, bus.address);
    else passed++;
    step();
    out_ready = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 6'd10; cdb_data = 32'hA00A;
    push_exp(32'h400, 32'hA00A, 32'h1000);
    step();
    for (int t = 17; t >= 11; t--) begin
      if (t != 13) begin
        cdb_tag = 6'(t); cdb_data = 32'hA000 + 32'(t);
        step();
      end
    end
    cdb_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || bus.address !== 32'h400 || count !== 4'd6)
      $display("[TB] FAIL fill_hold got v=%b addr=%h count=%0d want 1/400/6", out_valid, bus.address, count);
    else passed++;
    for (int i = 1; i < 8; i++)
      if (i != 3) push_exp(32'h400 + 32'(4 * i), 32'hA000 + 32'(10 + i), 32'h1000 + 32'(i));
    out_ready = 1'b1;
    for (int k = 0; k < 40 && !(count == 4'd0 && out_valid == 1'b0); k++) step();
    total++; if (count !== 4'd0 || out_valid !== 1'b0 || exp_q.size() != 0)
      $display("[TB] FAIL fill_drain got count=%0d v=%b pending=%0d want 0/0/0", count, out_valid, exp_q.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_insert(32'h500, 1'b1, 6'd0, 32'h51, 1'b1, 6'd0, 32'h52);
    push_exp(32'h500, 32'h51, 32'h52);
    step();
    set_insert(32'h510, 1'b0, 6'd20, 32'h0, 1'b1, 6'd0, 32'h60); step();
    set_insert(32'h514, 1'b1, 6'd0, 32'h61, 1'b1, 6'd0, 32'h62);
    push_exp(32'h514, 32'h61, 32'h62);
    step();
    set_insert(32'h518, 1'b0, 6'd21, 32'h0, 1'b1, 6'd0, 32'h63); step();
    set_insert(32'h51C, 1'b0, 6'd22, 32'h0, 1'b1, 6'd0, 32'h64); step();
    set_insert(32'h520, 1'b1, 6'd0, 32'h71, 1'b1, 6'd0, 32'h72);
    push_exp(32'h520, 32'h71, 32'h72);
    step();
    in_valid = 1'b0;
    total++; if (count !== 4'd5 || out_valid !== 1'b1 || bus.address !== 32'h500)
      $display("[TB] FAIL bp_setup got count=%0d v=%b addr=%h want 5/1/500", count, out_valid, bus.address);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (bus.address !== 32'h500 || bus.data_1 !== 32'h51 || count !== 4'd5)
        $display("[TB] FAIL bp_stable got addr=%h d1=%h count=%0d want 500/51/5", bus.address, bus.data_1, count);
      else passed++;
    end
    out_ready = 1'b1;
    step();
    total++; if (bus.address !== 32'h514 || count !== 4'd4)
      $display("[TB] FAIL bp_first got addr=%h count=%0d want 514/4", bus.address, count);
    else passed++;
    step();
    out_ready = 1'b0;
    total++; if (bus.address !== 32'h520 || count !== 4'd3 || out_valid !== 1'b1)
      $display("[TB] FAIL bp_second got addr=%h count=%0d v=%b want 520/3/1", bus.address, count, out_valid);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    #1;
    reset = 1'b1;
    #1;
    total++; if (count !== 4'd0 || out_valid !== 1'b0)
      $display("[TB] FAIL mid_reset got count=%0d v=%b want 0/0", count, out_valid);
    else passed++;
    total++; if (bus.address !== 32'h0 || bus.data_1 !== 32'h0 || bus.instr_name !== UNKNOWN ||
                 bus.instr_type !== XX || bus.flags !== 3'b000)
      $display("[TB] FAIL mid_reset_bus got addr=%h d1=%h name=%0d type=%0d want zeros", bus.address, bus.data_1, bus.instr_name, bus.instr_type);
    else passed++;
    exp_q.delete();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_insert(32'h600, 1'b0, 6'd0, 32'h0, 1'b1, 6'd0, 32'h5);
    cdb_valid = 1'b1; cdb_tag = 6'd0; cdb_data = 32'hFFFF;
    step();
    cdb_valid = 1'b0;
    set_insert(32'h604, 1'b0, 6'd30, 32'h0, 1'b1, 6'd0, 32'h6);
    step();
    in_valid = 1'b0;
    step();
    total++; if (count !== 4'd2 || out_valid !== 1'b0)
      $display("[TB] FAIL tag0_nomatch got count=%0d v=%b want 2/0", count, out_valid);
    else passed++;
    flush = 1'b1;
    set_insert(32'h608, 1'b1, 6'd0, 32'h1, 1'b1, 6'd0, 32'h2);
    #1;
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL flush_in_ready got %b want 0", in_ready); else passed++;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (count !== 4'd0 || out_valid !== 1'b0)
      $display("[TB] FAIL flush_clear got count=%0d v=%b want 0/0", count, out_valid);
    else passed++;
    out_ready = 1'b1;
    set_insert(32'h700, 1'b1, 6'd0, 32'h81, 1'b1, 6'd0, 32'h82);
    push_exp(32'h700, 32'h81, 32'h82);
    step();
    in_valid = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || bus.address !== 32'h700)
      $display("[TB] FAIL flush_after got v=%b addr=%h want 1/700", out_valid, bus.address);
    else passed++;
    step();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cdb_valid = 1'b0; cdb_tag = 6'd0; cdb_data = 32'h0;
    in_address = '0; in_immediate = '0; in_data_1 = '0; in_data_2 = '0;
    in_valid_1 = 1'b0; in_valid_2 = 1'b0; in_instr_name = UNKNOWN; in_instr_type = XX;
    in_regs = '0; in_flags = '0;
    test_reset();
    test_basic();
    test_wakeup();
    test_fill();
    test_back_to_back();
    test_reset_midstream();
    test_flush();
    total++; if (exp_q.size() != 0 || out_valid !== 1'b0)
      $display("[TB] FAIL final_drain got pending=%0d v=%b want 0/0", exp_q.size(), out_valid);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
